ripple_count_ctrl: RTL and testbench

//  Sequencer for the lab 3-bit-class counters, generalised to WIDTH bits.
//  - Owns a programmable-limit counter: start/stop/pause control, one-shot or auto-reload.
//  - Emits a 1-cycle done pulse at terminal count.
//  - Sits between the top-level button/switch logic and the counter display outputs.
//  - Replaces free-running ripple counting with a synchronous, controllable count.

---
 rtl/ripple_count_ctrl_if.sv | 32 +++
 rtl/ripple_count_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ripple_count_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ripple_count_ctrl_if.sv
// ---------------------------------------------------------------------------
// ripple_count_ctrl_if
// Control/status bundle between the button/switch logic (master) and the
// ripple_count_ctrl sequencer (slave). WIDTH must match the sequencer's WIDTH.
// ---------------------------------------------------------------------------
interface ripple_count_ctrl_if #(
   parameter int WIDTH = 3
);

   // Control from the front panel logic
   logic             start;
   logic             stop;
   logic             pause;
   logic             auto_reload;
   logic [WIDTH-1:0] load_val;

   // Status back to the display outputs
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, pause, auto_reload, load_val,
      input  count, busy, done
   );

   modport slave (
      input  start, stop, pause, auto_reload, load_val,
      output count, busy, done
   );

endinterface : ripple_count_ctrl_if

// File: rtl/ripple_count_ctrl.sv
// ---------------------------------------------------------------------------
// ripple_count_ctrl
// Synchronous programmable-limit counter sequencer (IDLE/RUN/HOLD/DONE) that
// replaces free-running ripple counting. Supports one-shot and auto-reload
// runs, pause/resume, abort, and a single-cycle done pulse at terminal count.
//
// Optional feature macro: COUNT_PRESCALE_EN
//   defined   -> the count advances once every PRESCALE clocks while in RUN
//   undefined -> every RUN cycle advances the count; PRESCALE is ignored
//
// Reset is synchronous and active-low on 'reset'. All outputs are registered.
// ---------------------------------------------------------------------------
module ripple_count_ctrl #(
   parameter int WIDTH    = 3,
   parameter int PRESCALE = 4
) (
   input  logic                clk,
   input  logic                reset,
   ripple_count_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             reload_q, reload_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] count_inc;
   logic             tick;

`ifdef COUNT_PRESCALE_EN
   // Prescaler needs at least one bit even when PRESCALE==1
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;

   // A tick fires on the last clock of each PRESCALE-long window in RUN
   always_comb begin
      tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
   end
`else
   // Without prescaling, every RUN cycle is a tick
   always_comb begin
      tick = (state_q == ST_RUN);
   end
`endif

   // Next-state and next-output decode; priority is stop > start > pause > tick
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path can leave it unassigned and infer a latch.
      state_d   = state_q;
      count_d   = count_q;
      limit_d   = limit_q;
      reload_d  = reload_q;
      done_d    = 1'b0;
      count_inc = count_q + WIDTH'(1);
`ifdef COUNT_PRESCALE_EN
      presc_d   = presc_q;
`endif

      if (bus.stop) begin
         // Abort from any state
         state_d = ST_IDLE;
         count_d = '0;
`ifdef COUNT_PRESCALE_EN
         presc_d = '0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               // A fresh run captures limit and reload mode only here
               if (bus.start) begin
                  limit_d  = bus.load_val;
                  reload_d = bus.auto_reload;
                  count_d  = '0;
`ifdef COUNT_PRESCALE_EN
                  presc_d  = '0;
`endif
                  if (bus.load_val != '0) begin
                     state_d = ST_RUN;
                  end else begin
                     // Zero limit: terminal count is reached immediately
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end
            end

            ST_RUN: begin
               // start is ignored while running; pause outranks the tick
               if (bus.pause) begin
                  state_d = ST_HOLD;
               end else begin
`ifdef COUNT_PRESCALE_EN
                  presc_d = tick ? '0 : presc_q + PW'(1);
`endif
                  if (tick) begin
                     if (count_q == limit_q) begin
                        // Only reachable in auto-reload mode: wrap and keep running
                        count_d = '0;
                     end else begin
                        count_d = count_inc;
                        if (count_inc == limit_q) begin
                           done_d = 1'b1;
                           if (!reload_q) begin
                              state_d = ST_DONE;
                           end
                        end
                     end
                  end
               end
            end

            ST_HOLD: begin
               // Count and prescaler frozen; resume on the next cycle
               if (!bus.pause) begin
                  state_d = ST_RUN;
               end
            end

            default: begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         endcase
      end

      busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         limit_q  <= '0;
         reload_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         limit_q  <= limit_d;
         reload_q <= reload_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifdef COUNT_PRESCALE_EN
   // Prescaler register, cleared on reset, start and stop
   always_ff @(posedge clk) begin
      if (!reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`endif

   // Registered outputs onto the bus
   always_comb begin
      bus.count = count_q;
      bus.busy  = busy_q;
      bus.done  = done_q;
   end

endmodule : ripple_count_ctrl

// File: tb/tb_ripple_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ripple_count_ctrl
// Directed self-checking bench for ripple_count_ctrl (WIDTH=3, PRESCALE=4).
// Build with COUNT_PRESCALE_EN defined to exercise the prescaled scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ripple_count_ctrl;

   localparam int WIDTH    = 3;
   localparam int PRESCALE = 4;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   ripple_count_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

   ripple_count_ctrl #(
      .WIDTH    (WIDTH),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report a mismatch
   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int c, input int b, input int d);
      check({tag, ".count"}, int'(bus_if.count), c);
      check({tag, ".busy"},  int'(bus_if.busy),  b);
      check({tag, ".done"},  int'(bus_if.done),  d);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      bus_if.start       = 1'b1;
      bus_if.stop        = 1'b0;
      bus_if.pause       = 1'b0;
      bus_if.auto_reload = 1'b0;
      bus_if.load_val    = 3'd5;
      reset              = 1'b0;

      // 1. reset held with start high
      step(); check_all("rst0", 0, 0, 0);
      step(); check_all("rst1", 0, 0, 0);
      reset        = 1'b1;
      bus_if.start = 1'b0;
      step(); check_all("idle", 0, 0, 0);

`ifndef COUNT_PRESCALE_EN
      // 2. one-shot to 5
      bus_if.load_val    = 3'd5;
      bus_if.auto_reload = 1'b0;
      bus_if.start       = 1'b1;
      step(); check_all("os_start", 0, 1, 0);
      bus_if.start = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step(); check_all($sformatf("os_%0d", i), i, (i != 5) ? 1 : 0, (i == 5) ? 1 : 0);
      end
      step(); check_all("os_hold0", 5, 0, 0);
      step(); check_all("os_hold1", 5, 0, 0);

      // 3. auto-reload at full-scale limit, restarted from DONE
      bus_if.load_val    = 3'd7;
      bus_if.auto_reload = 1'b1;
      bus_if.start       = 1'b1;
      step(); check_all("ar_start", 0, 1, 0);
      bus_if.start = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step(); check_all($sformatf("ar_%0d", k), k % 8, 1, ((k % 8) == 7) ? 1 : 0);
      end
      bus_if.stop = 1'b1;
      step(); check_all("ar_stop", 0, 0, 0);
      bus_if.stop        = 1'b0;
      bus_if.auto_reload = 1'b0;

      // 4. pause/resume; start and new load_val ignored while running
      bus_if.load_val = 3'd5;
      bus_if.start    = 1'b1;
      step(); check_all("pz_start", 0, 1, 0);
      bus_if.load_val = 3'd1;
      for (int i = 1; i <= 3; i++) begin
         step(); check_all($sformatf("pz_run%0d", i), i, 1, 0);
      end
      bus_if.start = 1'b0;
      bus_if.pause = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(); check_all($sformatf("pz_hold%0d", i), 3, 1, 0);
      end
      bus_if.pause = 1'b0;
      step(); check_all("pz_resume", 3, 1, 0);
      step(); check_all("pz_tick", 4, 1, 0);
      bus_if.start = 1'b1;
      bus_if.stop  = 1'b1;
      bus_if.pause = 1'b1;
      step(); check_all("pz_allhi", 0, 0, 0);
      bus_if.start = 1'b0;
      bus_if.stop  = 1'b0;
      bus_if.pause = 1'b0;
      step(); check_all("pz_idle", 0, 0, 0);

      // 5a. zero limit goes straight to DONE
      bus_if.load_val = 3'd0;
      bus_if.start    = 1'b1;
      step(); check_all("z_start", 0, 0, 1);
      bus_if.start = 1'b0;
      step(); check_all("z_after", 0, 0, 0);

      // 5b. reset in the middle of a run
      bus_if.load_val = 3'd5;
      bus_if.start    = 1'b1;
      step(); check_all("mr_start", 0, 1, 0);
      bus_if.start = 1'b0;
      step(); step(); check_all("mr_run2", 2, 1, 0);
      reset = 1'b0;
      step(); check_all("mr_rst", 0, 0, 0);
      reset = 1'b1;
      step(); check_all("mr_idle", 0, 0, 0);
`else
      // 6. prescaled one-shot to 2
      bus_if.load_val = 3'd2;
      bus_if.start    = 1'b1;
      step(); check_all("ps_start", 0, 1, 0);
      bus_if.start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         step(); check_all($sformatf("ps_%0d", c), c / 4, (c < 8) ? 1 : 0, (c == 8) ? 1 : 0);
      end
      step(); check_all("ps_done", 2, 0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_ripple_count_ctrl
